// File: rtl/crossdomain_arb_pkg.sv
// Shared types and default parameters for the cross-domain request arbiter.
package crossdomain_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        GRANT = 2'd2,
        ACK   = 2'd3
    } chan_state_e;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/crossdomain_req_arbiter_if.sv
// Request/acknowledge and grant bundle of the cross-domain arbiter.
interface crossdomain_req_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] ack_o;
    logic               gnt_valid;
    logic [IDW-1:0]     gnt_id;
    logic               gnt_ready;
    logic               busy;
    logic               err_o;
    logic [IDW-1:0]     err_id;

    modport master (
        input  req_i, gnt_ready,
        output ack_o, gnt_valid, gnt_id, busy, err_o, err_id
    );

    modport slave (
        output req_i, gnt_ready,
        input  ack_o, gnt_valid, gnt_id, busy, err_o, err_id
    );

endinterface

// File: rtl/sync_level_stages.sv
// Multi-flop level synchronizer for one asynchronous request line.
module sync_level_stages #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) ff <= '0;
        else       ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/crossdomain_req_arbiter.sv
// Round-robin arbiter for four-phase requests arriving from foreign clock domains.
// Optional ack-phase watchdog enabled by defining CDC_ARB_TIMEOUT_EN.
module crossdomain_req_arbiter
    import crossdomain_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    crossdomain_req_arbiter_if.master bus
);
    localparam int IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1)
    begin : g_bad_param
        $error("crossdomain_req_arbiter: parameter out of range");
    end

    chan_state_e        st [NUM_REQ];
    logic [NUM_REQ-1:0] req_s, pend, busy_v, ack_q;
    logic               gnt_valid_q;
    logic [IDW-1:0]     gnt_id_q, ptr, ptr_next, sel_id;
    logic               sel_found, sel_ok;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_chan
        sync_level_stages #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (bus.req_i[i]),
            .q     (req_s[i])
        );
        assign pend[i]   = (st[i] == PEND);
        assign busy_v[i] = (st[i] != IDLE);
    end

    // First pending channel at or after the rotate pointer.
    always_comb begin
        int j;
        j         = 0;
        sel_found = 1'b0;
        sel_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!sel_found && pend[j]) begin
                sel_found = 1'b1;
                sel_id    = IDW'(j);
            end
        end
    end

    assign sel_ok   = sel_found && !gnt_valid_q;
    assign ptr_next = (gnt_id_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_q + IDW'(1);

`ifdef CDC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0]      cnt [NUM_REQ];
    logic [NUM_REQ-1:0] blk, to_hit;
    logic               to_any, err_q;
    logic [IDW-1:0]     to_id, err_id_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_to
        assign to_hit[i] = (st[i] == ACK) && (cnt[i] >= CW'(TIMEOUT_CYCLES - 1));
    end

    // Only one timeout is reported per cycle; others stay saturated and fire later.
    always_comb begin
        to_any = 1'b0;
        to_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (to_hit[k]) begin
                to_any = 1'b1;
                to_id  = IDW'(k);
            end
        end
    end

    assign bus.err_o  = err_q;
    assign bus.err_id = err_id_q;
`else
    assign bus.err_o  = 1'b0;
    assign bus.err_id = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) st[i] <= IDLE;
            ack_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ptr         <= '0;
`ifdef CDC_ARB_TIMEOUT_EN
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
            blk      <= '0;
            err_q    <= 1'b0;
            err_id_q <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                case (st[i])
                    IDLE: begin
`ifdef CDC_ARB_TIMEOUT_EN
                        if (!req_s[i]) blk[i] <= 1'b0;
                        if (req_s[i] && !blk[i]) st[i] <= PEND;
`else
                        if (req_s[i]) st[i] <= PEND;
`endif
                    end
                    PEND: begin
                        if (!req_s[i])                       st[i] <= IDLE;
                        else if (sel_ok && sel_id == IDW'(i)) st[i] <= GRANT;
                    end
                    GRANT: begin
                        if (!req_s[i]) st[i] <= IDLE;
                        else if (bus.gnt_ready) begin
                            st[i]    <= ACK;
                            ack_q[i] <= 1'b1;
`ifdef CDC_ARB_TIMEOUT_EN
                            cnt[i]   <= '0;
`endif
                        end
                    end
                    ACK: begin
                        if (!req_s[i]) begin
                            st[i]    <= IDLE;
                            ack_q[i] <= 1'b0;
                        end
`ifdef CDC_ARB_TIMEOUT_EN
                        else if (to_any && to_id == IDW'(i)) begin
                            st[i]    <= IDLE;
                            ack_q[i] <= 1'b0;
                            blk[i]   <= 1'b1;
                        end else if (cnt[i] < CW'(TIMEOUT_CYCLES - 1)) begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
`endif
                    end
                    default: st[i] <= IDLE;
                endcase
            end

            // A dropped request aborts the grant without moving the pointer.
            if (gnt_valid_q) begin
                if (!req_s[gnt_id_q]) begin
                    gnt_valid_q <= 1'b0;
                end else if (bus.gnt_ready) begin
                    gnt_valid_q <= 1'b0;
                    ptr         <= ptr_next;
                end
            end else if (sel_ok) begin
                gnt_valid_q <= 1'b1;
                gnt_id_q    <= sel_id;
            end

`ifdef CDC_ARB_TIMEOUT_EN
            err_q    <= to_any;
            err_id_q <= to_any ? to_id : '0;
`endif
        end
    end

    assign bus.ack_o     = ack_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.busy      = |busy_v;

endmodule

// File: doc/crossdomain_req_arbiter.md
CROSSDOMAIN_REQ_ARBITER -- requirements
Module: crossdomain_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requester channels (2..16).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth per req line (2..4).
REQ-003 Parameter TIMEOUT_CYCLES, default 255, ack-phase watchdog limit (used only with CDC_ARB_TIMEOUT_EN).
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_i  input  NUM_REQ  four-phase request levels from foreign domains, asynchronous to clk.
REQ-007 ack_o  output  NUM_REQ  four-phase acknowledge levels, registered.
REQ-008 gnt_valid  output  1  a granted request is presented downstream.
REQ-009 gnt_id  output  clog2(NUM_REQ)  index of granted channel, valid while gnt_valid.
REQ-010 gnt_ready  input  1  downstream accepts grant when high with gnt_valid.
REQ-011 busy  output  1  high when any channel is not IDLE.
REQ-012 err_o  output  1  one-cycle timeout pulse (CDC_ARB_TIMEOUT_EN only).
REQ-013 err_id  output  clog2(NUM_REQ)  channel that timed out, valid with err_o (CDC_ARB_TIMEOUT_EN only).

Function
REQ-014 Each req_i bit SHALL pass through SYNC_STAGES flops before any use; req_s denotes the synchronized value.
REQ-015 Each channel SHALL run FSM IDLE -> PEND (req_s=1) -> GRANT (selected by arbiter) -> ACK (gnt_valid&gnt_ready) -> IDLE (req_s=0).
REQ-016 ack_o[i] SHALL be 1 exactly while channel i is in ACK.
REQ-017 In ACK, channel SHALL return to IDLE the cycle after req_s falls; ack_o drops on that same transition.
REQ-018 Channel in IDLE with req_s=1 SHALL re-enter PEND only after a full ack low phase (no re-grant while ack_o=1).
REQ-019 Arbiter SHALL hold at most one channel in GRANT; new selection only when no grant outstanding.
REQ-020 Selection SHALL be round-robin: search starts at (last granted id + 1) mod NUM_REQ; after reset pointer = 0.
REQ-021 gnt_valid SHALL assert the cycle after selection and hold, with gnt_id stable, until gnt_ready sampled high.
REQ-022 On gnt_valid&gnt_ready, gnt_valid SHALL deassert next cycle; a new grant MAY assert the following cycle (1 idle cycle minimum between grants).
REQ-023 Latency req_i rise -> gnt_valid SHALL be SYNC_STAGES+2 cycles with no competition.
REQ-024 req_s dropping while in PEND or GRANT (protocol violation) SHALL return channel to IDLE; an outstanding gnt_valid SHALL deassert next cycle and rotate pointer unchanged.
REQ-025 Simultaneous PEND on all channels SHALL be served in strict rotation, each exactly once per round.
REQ-026 Channels in ACK SHALL not block arbitration of others.

Reset
REQ-027 reset SHALL clear synchronizers, all FSMs to IDLE, pointer to 0, ack_o=0, gnt_valid=0, gnt_id=0, busy=0, err_o=0, err_id=0.
REQ-028 reset mid-handshake SHALL drop ack_o next cycle; requests still high afterwards are treated as new.

Configuration
REQ-029 Macro CDC_ARB_TIMEOUT_EN defined: per-channel counter runs in ACK; reaching TIMEOUT_CYCLES forces channel to IDLE, ack_o low, pulses err_o with err_id; channel then ignores req_s until req_s seen low.
REQ-030 Macro undefined: no counters, ACK waits indefinitely, err_o and err_id tied 0.

Structure
REQ-031 Package crossdomain_arb_pkg SHALL hold channel-state enum (IDLE, PEND, GRANT, ACK) and default parameter constants.
REQ-032 Sub-module sync_level_stages SHALL implement the SYNC_STAGES-deep synchronizer, instantiated per channel.

Verification
REQ-033 NUM_REQ=4: req_i[2] rises, gnt_ready=1 -> gnt_valid at cycle 4, gnt_id=2, ack_o[2]=1; drop req -> ack_o[2]=0 after 3 cycles.
REQ-034 All req_i rise same cycle, gnt_ready=1 -> grant order 0,1,2,3, each once, ack_o bits set in that order.
REQ-035 gnt_ready held 0 for 10 cycles -> gnt_valid and gnt_id=1 stable throughout, no ack_o change.
REQ-036 req_i[1] drops while in GRANT -> gnt_valid deasserts, ack_o[1] stays 0, next pending channel granted.
REQ-037 CDC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, req_i[3] held high after ack -> err_o pulse, err_id=3, ack_o[3]=0; no regrant until req_i[3] low then high.
REQ-038 reset asserted during ACK of channel 0 -> all outputs 0 next cycle, pointer 0, req still high regranted after SYNC_STAGES+2.
